// File: rtl/voting_machine_n.sv
// Parametrised ballot unit: per-button hold qualifiers, an arm/vote/feedback FSM,
// saturating per-candidate counters and live winner/tie/total statistics.
module voting_machine_n #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 50000000,
  parameter int FB_CYCLES   = 50000000,
  parameter int IDX_W       = (NUM_CAND > 2) ? $clog2(NUM_CAND) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [NUM_CAND-1:0]    buttons_n,
  input  logic                   ballot_arm,
  output logic [CNT_W-1:0]       led,
  output logic                   armed,
  output logic                   vote_accept,
  output logic                   vote_reject,
  output logic [IDX_W-1:0]       winner_idx,
  output logic                   tie,
  output logic [CNT_W+IDX_W-1:0] total_votes
);

  localparam int TMR_W = $clog2(HOLD_CYCLES + 1);
  localparam int FB_W  = $clog2(FB_CYCLES + 1);
  localparam int TOT_W = CNT_W + IDX_W;

  localparam logic [TMR_W-1:0] HOLD_T  = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_M1 = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [FB_W-1:0]  FB_T    = FB_W'(FB_CYCLES);
  localparam logic [FB_W-1:0]  FB_LAST = FB_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_FEEDBACK
  } state_e;

  // ---------------------------------------------------------------- qualifier
  logic [TMR_W-1:0]    timer_q [NUM_CAND];
  logic [TMR_W-1:0]    timer_d [NUM_CAND];
  logic [NUM_CAND-1:0] qual_q, qual_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    for (int i = 0; i < NUM_CAND; i++) begin
      timer_d[i] = '0;
      qual_d[i]  = 1'b0;
      if (!buttons_n[i]) begin
        timer_d[i] = (timer_q[i] == HOLD_T) ? timer_q[i] : timer_q[i] + 1'b1;
        qual_d[i]  = (timer_q[i] == HOLD_M1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) timer_q[i] <= '0;
      qual_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) timer_q[i] <= timer_d[i];
      qual_q <= qual_d;
    end
  end

  // ---------------------------------------------------------- ballot decode
  logic             qual_any, qual_multi;
  logic [IDX_W-1:0] sel_idx;

  assign qual_any   = |qual_q;
  assign qual_multi = |(qual_q & (qual_q - 1'b1));

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (qual_q[i]) sel_idx = IDX_W'(i);
    end
  end

  // ---------------------------------------------------------- display value
  logic [CNT_W-1:0] cnt_q [NUM_CAND];
  logic [IDX_W-1:0] winner_q;
  logic [CNT_W-1:0] disp_val;

  // Walk from the top so the lowest pressed index has the final say.
  always_comb begin
    disp_val = cnt_q[winner_q];
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (!buttons_n[i]) disp_val = cnt_q[i];
    end
  end

  // -------------------------------------------------------------------- FSM
  state_e           state_q;
  logic [FB_W-1:0]  fb_q;
  logic             armed_q, accept_q, reject_q;
  logic [CNT_W-1:0] led_q;

  // NOTE: the vote counters are plain flops, not a RAM, so they take the
  // async reset like any other state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fb_q     <= '0;
      armed_q  <= 1'b0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      led_q    <= '0;
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
    end else begin
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      led_q    <= mode ? disp_val : '0;
      case (state_q)
        S_IDLE: begin
          if (!mode && ballot_arm) begin
            state_q <= S_ARMED;
            armed_q <= 1'b1;
          end
        end
        S_ARMED: begin
          if (mode) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
          end else if (qual_any) begin
            if (qual_multi) begin
              reject_q <= 1'b1;
            end else begin
              accept_q <= 1'b1;
              if (cnt_q[sel_idx] != CNT_MAX) cnt_q[sel_idx] <= cnt_q[sel_idx] + 1'b1;
            end
            state_q <= S_FEEDBACK;
            armed_q <= 1'b0;
            fb_q    <= FB_T;
            led_q   <= '1;
          end
        end
        S_FEEDBACK: begin
          // The entry edge already lit the LEDs, so FB_CYCLES-1 more are needed.
          if (fb_q == FB_LAST) begin
            state_q <= S_IDLE;
          end else begin
            fb_q  <= fb_q - 1'b1;
            led_q <= '1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- statistics
  logic [CNT_W-1:0] max_v;
  logic             max_seen;
  logic [IDX_W-1:0] winner_d;
  logic             tie_d, tie_q;
  logic [TOT_W-1:0] total_d, total_q;

  always_comb begin
    max_v    = cnt_q[0];
    winner_d = '0;
    total_d  = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      total_d = total_d + TOT_W'(cnt_q[i]);
      if (cnt_q[i] > max_v) begin
        max_v    = cnt_q[i];
        winner_d = IDX_W'(i);
      end
    end
    max_seen = 1'b0;
    tie_d    = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cnt_q[i] == max_v) begin
        tie_d    = tie_d | max_seen;
        max_seen = 1'b1;
      end
    end
    if (max_v == '0) tie_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      winner_q <= '0;
      tie_q    <= 1'b0;
      total_q  <= '0;
    end else begin
      winner_q <= winner_d;
      tie_q    <= tie_d;
      total_q  <= total_d;
    end
  end

  assign led         = led_q;
  assign armed       = armed_q;
  assign vote_accept = accept_q;
  assign vote_reject = reject_q;
  assign winner_idx  = winner_q;
  assign tie         = tie_q;
  assign total_votes = total_q;

endmodule

// File: tb/tb_voting_machine_n.sv
// Directed bench for voting_machine_n: expected vote pulses are queued as each
// ballot is driven and popped by a monitor when the DUT pulses.
module tb_voting_machine_n;

  localparam int NC   = 4;
  localparam int CW   = 4;
  localparam int IW   = 2;
  localparam int HOLD = 4;
  localparam int FB   = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mode = 1'b0;
  logic [NC-1:0] buttons_n = '1;
  logic          ballot_arm = 1'b0;
  logic [CW-1:0] led;
  logic          armed, vote_accept, vote_reject, tie;
  logic [IW-1:0] winner_idx;
  logic [CW+IW-1:0] total_votes;

  voting_machine_n #(
    .NUM_CAND(NC), .CNT_W(CW), .HOLD_CYCLES(HOLD), .FB_CYCLES(FB), .IDX_W(IW)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .buttons_n(buttons_n),
    .ballot_arm(ballot_arm), .led(led), .armed(armed),
    .vote_accept(vote_accept), .vote_reject(vote_reject),
    .winner_idx(winner_idx), .tie(tie), .total_votes(total_votes)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic acc; logic rej;} pulse_t;

  pulse_t exp_q[$];
  pulse_t mon_e;
  int     exp_cnt[NC];
  int     n_vec = 0;
  int     n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_total();
    int s = 0;
    for (int i = 0; i < NC; i++) s += exp_cnt[i];
    return s;
  endfunction

  function automatic int exp_winner();
    int w = 0;
    for (int i = 1; i < NC; i++) if (exp_cnt[i] > exp_cnt[w]) w = i;
    return w;
  endfunction

  function automatic int exp_tie();
    int m = exp_cnt[exp_winner()];
    int n = 0;
    for (int i = 0; i < NC; i++) if (exp_cnt[i] == m) n++;
    return (m > 0 && n >= 2) ? 1 : 0;
  endfunction

  // Scoreboard side: every pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && (vote_accept || vote_reject)) begin
      check("pulse_exclusive", 32'(vote_accept & vote_reject), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, vote_accept, vote_reject}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {30'd0, vote_accept, vote_reject}, {30'd0, mon_e.acc, mon_e.rej});
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_armed"}, 32'(armed), 32'd0);
    check({tag, "_pulses"}, 32'({vote_accept, vote_reject}), 32'd0);
    check({tag, "_winner"}, 32'(winner_idx), 32'd0);
    check({tag, "_tie"}, 32'(tie), 32'd0);
    check({tag, "_total"}, 32'(total_votes), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; buttons_n = '1; mode = 1'b0; ballot_arm = 1'b0;
    for (int i = 0; i < NC; i++) exp_cnt[i] = 0;
    exp_q.delete();
    @(negedge clock);
    check_idle_outputs("reset_state");
    reset = 1'b0;
  endtask

  // Arm, optionally bounce the press (release at timer 3), then hold until
  // the pulse and follow the LED feedback back to IDLE.
  task automatic ballot(input logic [NC-1:0] mask, input bit bounce);
    bit acc;
    int lat;
    acc = ($countones(mask) == 1);
    @(negedge clock); ballot_arm = 1'b1;
    @(negedge clock); ballot_arm = 1'b0;
    check("armed_set", 32'(armed), 32'd1);
    if (bounce) begin
      buttons_n = ~mask;
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        check("bounce_no_pulse", 32'(vote_accept | vote_reject), 32'd0);
      end
      buttons_n = '1;
      @(negedge clock);
    end
    exp_q.push_back('{acc: acc, rej: !acc});
    if (acc) begin
      for (int i = 0; i < NC; i++)
        if (mask[i] && exp_cnt[i] < (1 << CW) - 1) exp_cnt[i]++;
    end
    buttons_n = ~mask;
    lat = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      lat++;
      if (vote_accept || vote_reject) break;
    end
    check("pulse_latency", 32'(lat), 32'd5);
    check("fb_led_0", 32'(led), 32'hF);
    check("armed_clear", 32'(armed), 32'd0);
    @(negedge clock);
    check("pulse_width", 32'(vote_accept | vote_reject), 32'd0);
    check("fb_led_1", 32'(led), 32'hF);
    check("total", 32'(total_votes), 32'(exp_total()));
    check("winner", 32'(winner_idx), 32'(exp_winner()));
    check("tie", 32'(tie), 32'(exp_tie()));
    buttons_n = '1;
    @(negedge clock);
    check("fb_led_2", 32'(led), 32'hF);
    @(negedge clock);
    check("fb_done_led", 32'(led), 32'd0);
    check("fb_done_armed", 32'(armed), 32'd0);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < NC; i++) exp_cnt[i] = 0;

    // Single accepted vote for candidate 1.
    do_reset();
    ballot(4'b0010, 1'b0);

    // Press without arming: ignored.
    do_reset();
    @(negedge clock);
    buttons_n = 4'b1110;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (vote_accept || vote_reject) pulses++;
      if (k == 9) check("noarm_armed", 32'(armed), 32'd0);
    end
    buttons_n = '1;
    check("noarm_pulses", 32'(pulses), 32'd0);
    @(negedge clock);
    check("noarm_total", 32'(total_votes), 32'd0);

    // Two buttons qualify together: spoiled ballot.
    ballot(4'b1100, 1'b0);

    // Bounced press then 16 more ballots on candidate 3: saturation.
    do_reset();
    ballot(4'b1000, 1'b1);
    for (int n = 0; n < 16; n++) ballot(4'b1000, 1'b0);
    check("sat_total", 32'(total_votes), 32'd15);

    // Tie between candidates 0 and 2, then result display.
    do_reset();
    ballot(4'b0001, 1'b0);
    ballot(4'b0100, 1'b0);
    ballot(4'b0001, 1'b0);
    ballot(4'b0100, 1'b0);
    check("tie_flag", 32'(tie), 32'd1);
    check("tie_winner", 32'(winner_idx), 32'd0);
    mode = 1'b1; buttons_n = 4'b1011;
    @(negedge clock);
    check("disp_btn2", 32'(led), 32'(exp_cnt[2]));
    buttons_n = 4'b1101;
    @(negedge clock);
    check("disp_btn1", 32'(led), 32'(exp_cnt[1]));
    buttons_n = '1;
    @(negedge clock);
    check("disp_winner", 32'(led), 32'(exp_cnt[0]));
    mode = 1'b0;
    @(negedge clock);
    check("vote_mode_led", 32'(led), 32'd0);

    // Switching to display mode while armed cancels the ballot.
    ballot_arm = 1'b1;
    @(negedge clock); ballot_arm = 1'b0;
    check("cancel_armed", 32'(armed), 32'd1);
    mode = 1'b1;
    @(negedge clock);
    check("cancel_idle", 32'(armed), 32'd0);
    mode = 1'b0;

    // Async reset in the middle of FEEDBACK.
    @(negedge clock); ballot_arm = 1'b1;
    @(negedge clock); ballot_arm = 1'b0;
    exp_q.push_back('{acc: 1'b1, rej: 1'b0});
    buttons_n = 4'b1101;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (vote_accept) break;
    end
    @(negedge clock);
    check("midfb_led_on", 32'(led), 32'hF);
    #2 reset = 1'b1;
    #1 check_idle_outputs("midfb_reset");
    for (int i = 0; i < NC; i++) exp_cnt[i] = 0;
    buttons_n = '1;
    @(negedge clock); reset = 1'b0;

    // Async reset in the middle of a hold, then a clean ballot.
    @(negedge clock); ballot_arm = 1'b1;
    @(negedge clock); ballot_arm = 1'b0;
    buttons_n = 4'b1011;
    @(negedge clock);
    @(negedge clock);
    check("midhold_armed", 32'(armed), 32'd1);
    #2 reset = 1'b1;
    #1 check_idle_outputs("midhold_reset");
    buttons_n = '1;
    @(negedge clock); reset = 1'b0;
    ballot(4'b0100, 1'b0);

    @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voting_machine_n.md
Name: voting_machine_n

Overview:
Parametrised ballot unit and next-generation replacement for the fixed 4-candidate voting top. It adds NUM_CAND candidate channels, configurable hold and feedback times, and a poll-worker arm/ballot FSM (one vote per arm). Multi-press ballots are rejected, counters saturate, and a live winner/tie/total is computed. It sits directly behind the board buttons and drives the LED bank.

Parameters:
NUM_CAND, 4, number of candidate buttons/counters (2..16)
CNT_W, 8, width of each vote counter and of led
HOLD_CYCLES, 50000000, consecutive pressed cycles needed to qualify a press (>=2)
FB_CYCLES, 50000000, length of the all-on LED feedback after an accepted or rejected ballot (>=1)
IDX_W, $clog2(NUM_CAND), width of candidate index outputs (min 1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
mode  in  1  0 = voting, 1 = result display
buttons_n  in  NUM_CAND  active-low candidate buttons; bit i = candidate i
ballot_arm  in  1  poll-worker arm request, level-sampled
led  out  CNT_W  LED bank
armed  out  1  ballot open, waiting for a vote
vote_accept  out  1  one-cycle pulse, vote counted
vote_reject  out  1  one-cycle pulse, ballot spoiled
winner_idx  out  IDX_W  index of the highest count (lowest index on ties)
tie  out  1  two or more candidates share the maximum, and maximum > 0
total_votes  out  CNT_W+IDX_W  sum of all counters

Behaviour:
- Reset (async assert, sync release): all counters, press timers and outputs go to 0; FSM goes to IDLE.
- Press qualifier, per channel i:
  - timer increments while buttons_n[i]==0 and saturates at HOLD_CYCLES.
  - Release clears the timer in the same edge.
  - qual[i] is registered. It is high for exactly one cycle, the cycle after the edge on which the timer reaches HOLD_CYCLES.
  - Holding longer gives no repeat. The button must be released to re-qualify.
- FSM states: IDLE, ARMED, FEEDBACK.
  - IDLE: armed=0. Moves to ARMED when mode==0 and ballot_arm==1. Any qual in IDLE is ignored, with no pulse.
  - ARMED: armed=1.
    - If mode==1: back to IDLE, no pulse.
    - If exactly one qual bit is set: counter[i] increments and vote_accept=1 on the same edge; go to FEEDBACK.
    - If two or more qual bits are set in the same cycle: no count, vote_reject=1, go to FEEDBACK.
    - ballot_arm held high while ARMED has no effect.
  - FEEDBACK: a down-counter is loaded with FB_CYCLES. led is all ones for exactly FB_CYCLES cycles, then the FSM goes to IDLE. ballot_arm is ignored. A mode change does not abort FEEDBACK.
- Counters: an increment at 2^CNT_W-1 holds that value (saturate) and still pulses vote_accept.
- vote_accept and vote_reject are registered, high one cycle, and never high together.
- led:
  - Voting mode outside FEEDBACK: 0.
  - mode==1: led = counter of the lowest-index pressed button. With no button pressed, led = counter[winner_idx].
  - led is registered with 1-cycle latency from buttons_n/mode.
- winner_idx, tie and total_votes are registered. Each updates the cycle after the counter change, in all modes.
  - All counters zero: winner_idx=0, tie=0.
- Arithmetic is unsigned. total_votes cannot overflow, given its width.
- Reset mid-FEEDBACK or mid-hold: immediate return to reset values, with no pulse.

Test Plan:
Use NUM_CAND=4, CNT_W=4, HOLD_CYCLES=4, FB_CYCLES=3 throughout.
- Reset, arm 1 cycle, hold buttons_n=4'b1101 for 6 cycles -> vote_accept exactly once, 5 cycles after the first low sample. counter1=1, total_votes=1, winner_idx=1, led=4'hF for 3 cycles, then IDLE.
- No arm, hold button 0 for 10 cycles -> no pulse, all counters 0, armed=0.
- Arm, press buttons 2 and 3 on the same cycle for 4 cycles -> vote_reject pulse, counters unchanged, 3-cycle feedback.
- Arm, press button 3 with release at count 3 and re-press for 4 -> one accept, counter3=1. Repeat 16 ballots on button 3 -> counter3 saturates at 15, total_votes=15.
- Cast 2 votes for candidate 0 and 2 for candidate 2 -> tie=1, winner_idx=0. In mode=1 with button 2 pressed, led=2 one cycle later. Release -> led=counter[0]=2.
- Assert reset asynchronously mid-FEEDBACK and mid-hold -> all outputs 0 immediately. After release, the next qualified press while ARMED counts normally.
